pipe_run_ctrl: RTL

Run-control sequencer for the RV pipeline core. Holds the pipeline in reset after power-up, then gates instruction fetch through run, halt, single/multi-step and PC-breakpoint commands, and counts retired instructions. Sits between the core's fetch-stall/reset inputs and the debug/test command source, and observes the retire stage (the same point that drives the write-back debug outputs).

---
 rtl/pipe_run_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_run_ctrl.sv
// pipe_run_ctrl: run-control sequencer for the pipeline core.
// It holds the pipeline in reset after power-up. It then gates instruction fetch
// through run, halt, step and PC-breakpoint commands, and counts retired instructions.
// Every output is a register. Each output's next value is decoded from the next state,
// so the output changes on the same edge as the state that explains it.

module pipe_run_ctrl #(
   parameter int unsigned RESET_CYCLES = 4,
   parameter int unsigned DRAIN_CYCLES = 4
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cmd_valid,
   output logic        cmd_ready,
   input  logic [1:0]  cmd_op,
   input  logic [31:0] cmd_arg,
   input  logic        bp_en,
   input  logic [31:0] bp_pc,
   input  logic        retire_valid,
   input  logic [31:0] retire_pc,
   output logic        pipe_rst,
   output logic        pipe_stall,
   output logic [2:0]  state,
   output logic        halted,
   output logic [1:0]  halt_cause,
   output logic [31:0] retired_cnt
);

   typedef enum logic [2:0] {
      ST_RESET_HOLD = 3'd0,
      ST_HALTED     = 3'd1,
      ST_RUN        = 3'd2,
      ST_STEP       = 3'd3,
      ST_DRAIN      = 3'd4
   } state_e;

   localparam logic [1:0] OP_RUN   = 2'd0;
   localparam logic [1:0] OP_HALT  = 2'd1;
   localparam logic [1:0] OP_STEP  = 2'd2;
   localparam logic [1:0] OP_CLEAR = 2'd3;

   localparam logic [1:0] CAUSE_NONE = 2'd0;
   localparam logic [1:0] CAUSE_CMD  = 2'd1;
   localparam logic [1:0] CAUSE_STEP = 2'd2;
   localparam logic [1:0] CAUSE_BP   = 2'd3;

   // Counter widths are sized to the last count value. A parameter of 1 still gets a 1-bit counter.
   localparam int unsigned HOLD_W  = (RESET_CYCLES > 1) ? $clog2(RESET_CYCLES) : 1;
   localparam int unsigned DRAIN_W = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
   localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
   localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

   state_e              state_q, state_d;
   logic                pipe_rst_q, pipe_rst_d;
   logic                pipe_stall_q, pipe_stall_d;
   logic                cmd_ready_q, cmd_ready_d;
   logic                halted_q, halted_d;
   logic [1:0]          halt_cause_q, halt_cause_d;
   logic [31:0]         retired_cnt_q, retired_cnt_d;
   logic [HOLD_W-1:0]   hold_cnt_q, hold_cnt_d;
   logic [DRAIN_W-1:0]  drain_cnt_q, drain_cnt_d;
   logic [31:0]         step_rem_q, step_rem_d;

   logic cmd_fire;
   logic running;
   logic bp_hit;
   logic step_done;
   logic halt_cmd;

   // cmd_ready_q is already low in RESET_HOLD and DRAIN, so every accepted command is legal here.
   assign cmd_fire  = cmd_valid & cmd_ready_q;
   assign running   = (state_q == ST_RUN) | (state_q == ST_STEP);
   assign bp_hit    = running & bp_en & retire_valid & (retire_pc == bp_pc);
   assign step_done = (state_q == ST_STEP) & retire_valid & (step_rem_q == 32'd1);
   assign halt_cmd  = running & cmd_fire & (cmd_op == OP_HALT);

   // Next-state, counter and halt-cause decode. The halt causes are ordered BP, then STEP, then CMD.
   always_comb begin
      state_d      = state_q;
      hold_cnt_d   = hold_cnt_q;
      drain_cnt_d  = drain_cnt_q;
      step_rem_d   = step_rem_q;
      halt_cause_d = halt_cause_q;

      case (state_q)
         ST_RESET_HOLD: begin
            if (hold_cnt_q == HOLD_LAST) begin
               state_d    = ST_HALTED;
               hold_cnt_d = '0;
            end else begin
               hold_cnt_d = hold_cnt_q + 1'b1;
            end
         end

         ST_HALTED: begin
            if (cmd_fire) begin
               if (cmd_op == OP_RUN) begin
                  state_d = ST_RUN;
               end else if (cmd_op == OP_STEP) begin
                  state_d    = ST_STEP;
                  // A step count of zero is treated as a single step.
                  step_rem_d = (cmd_arg == 32'd0) ? 32'd1 : cmd_arg;
               end
            end
         end

         ST_RUN: begin
            if (bp_hit) begin
               state_d      = ST_DRAIN;
               drain_cnt_d  = '0;
               halt_cause_d = CAUSE_BP;
            end else if (halt_cmd) begin
               state_d      = ST_DRAIN;
               drain_cnt_d  = '0;
               halt_cause_d = CAUSE_CMD;
            end
         end

         ST_STEP: begin
            if (retire_valid) begin
               step_rem_d = step_rem_q - 32'd1;
            end
            if (bp_hit) begin
               state_d      = ST_DRAIN;
               drain_cnt_d  = '0;
               halt_cause_d = CAUSE_BP;
            end else if (step_done) begin
               state_d      = ST_DRAIN;
               drain_cnt_d  = '0;
               halt_cause_d = CAUSE_STEP;
            end else if (halt_cmd) begin
               state_d      = ST_DRAIN;
               drain_cnt_d  = '0;
               halt_cause_d = CAUSE_CMD;
            end
         end

         ST_DRAIN: begin
            if (drain_cnt_q == DRAIN_LAST) begin
               state_d     = ST_HALTED;
               drain_cnt_d = '0;
            end else begin
               drain_cnt_d = drain_cnt_q + 1'b1;
            end
         end

         default: begin
            state_d = ST_RESET_HOLD;
         end
      endcase
   end

   // Retire counter. CLEAR overrides the increment, but a retire in the same cycle still counts.
   always_comb begin
      retired_cnt_d = retired_cnt_q;
      if (state_q != ST_RESET_HOLD) begin
         if (cmd_fire && (cmd_op == OP_CLEAR)) begin
            retired_cnt_d = {31'd0, retire_valid};
         end else if (retire_valid) begin
            retired_cnt_d = retired_cnt_q + 32'd1;
         end
      end
   end

   // The output registers are decoded from the next state, so they line up with state_q.
   always_comb begin
      pipe_rst_d   = (state_d == ST_RESET_HOLD);
      pipe_stall_d = (state_d == ST_RESET_HOLD) | (state_d == ST_HALTED) | (state_d == ST_DRAIN);
      cmd_ready_d  = (state_d == ST_HALTED) | (state_d == ST_RUN) | (state_d == ST_STEP);
      halted_d     = (state_d == ST_HALTED);
   end

   // State and output registers. Reset is asynchronous and discards any pending step count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q       <= ST_RESET_HOLD;
         pipe_rst_q    <= 1'b1;
         pipe_stall_q  <= 1'b1;
         cmd_ready_q   <= 1'b0;
         halted_q      <= 1'b0;
         halt_cause_q  <= CAUSE_NONE;
         retired_cnt_q <= 32'd0;
         hold_cnt_q    <= '0;
         drain_cnt_q   <= '0;
         step_rem_q    <= 32'd0;
      end else begin
         state_q       <= state_d;
         pipe_rst_q    <= pipe_rst_d;
         pipe_stall_q  <= pipe_stall_d;
         cmd_ready_q   <= cmd_ready_d;
         halted_q      <= halted_d;
         halt_cause_q  <= halt_cause_d;
         retired_cnt_q <= retired_cnt_d;
         hold_cnt_q    <= hold_cnt_d;
         drain_cnt_q   <= drain_cnt_d;
         step_rem_q    <= step_rem_d;
      end
   end

   assign state       = state_q;
   assign pipe_rst    = pipe_rst_q;
   assign pipe_stall  = pipe_stall_q;
   assign cmd_ready   = cmd_ready_q;
   assign halted      = halted_q;
   assign halt_cause  = halt_cause_q;
   assign retired_cnt = retired_cnt_q;

endmodule
